// File: rtl/regfile_alu_sequencer.sv
// Command sequencer for the register-file/ALU datapath: valid/ready command FIFO, in-order issue FSM, read-response port.
// Optional RETIRE_COUNT_EN builds a 16-bit retired-command counter; otherwise retireCount is tied to 0.
module regfile_alu_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [1:0]        cmdOp,
    input  logic [2:0]        cmdFunc,
    input  logic [ADDR_W-1:0] cmdDest,
    input  logic [ADDR_W-1:0] cmdLeft,
    input  logic [ADDR_W-1:0] cmdRight,
    input  logic [DATA_W-1:0] cmdImm,
    output logic              respValid,
    input  logic              respReady,
    output logic [DATA_W-1:0] respData,
    output logic              carryFlag,
    output logic              busy,
    output logic [DATA_W-1:0] regDataIn,
    output logic [2:0]        regFunc,
    output logic              regCrIn,
    output logic [ADDR_W-1:0] regLeftAddr,
    output logic [ADDR_W-1:0] regRightAddr,
    output logic [ADDR_W-1:0] regDestAddr,
    output logic              regWriteEn,
    output logic              regSelInput,
    input  logic [DATA_W-1:0] regDataOut,
    input  logic              regCrOut,
    output logic [15:0]       retireCount
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [1:0] {OP_LOADI = 2'd0, OP_ALU = 2'd1, OP_ALUC = 2'd2, OP_READ = 2'd3} cmdOpT;
    typedef enum logic [1:0] {ISSUE, CARRY, READ, RESP} stateT;

    typedef struct packed {
        cmdOpT             op;
        logic [2:0]        func;
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] left;
        logic [ADDR_W-1:0] right;
        logic [DATA_W-1:0] imm;
    } cmdT;

    cmdT             fifoMem [DEPTH];
    cmdT             head;
    logic [PTR_W:0]  wrPtr, rdPtr;
    logic            empty, full, push, pop;
    stateT           state, stateNext;

    logic [DATA_W-1:0] dataInNext, respDataNext;
    logic [2:0]        funcNext;
    logic              crInNext, writeEnNext, selInputNext, respValidNext, carryNext;
    logic [ADDR_W-1:0] leftNext, rightNext, destNext;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign cmdReady = !full;
    assign push     = cmdValid && !full;
    assign head     = fifoMem[rdPtr[PTR_W-1:0]];
    assign busy     = !empty || (state != ISSUE);

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr[PTR_W-1:0]] <= '{op: cmdOpT'(cmdOp), func: cmdFunc, dest: cmdDest,
                                           left: cmdLeft, right: cmdRight, imm: cmdImm};
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stateNext     = state;
        pop           = 1'b0;
        dataInNext    = regDataIn;
        funcNext      = regFunc;
        crInNext      = regCrIn;
        leftNext      = regLeftAddr;
        rightNext     = regRightAddr;
        destNext      = regDestAddr;
        selInputNext  = regSelInput;
        writeEnNext   = 1'b0;
        respValidNext = respValid;
        respDataNext  = respData;
        carryNext     = carryFlag;
        unique case (state)
            ISSUE: if (!empty) begin
                pop = 1'b1;
                unique case (head.op)
                    OP_LOADI: begin
                        selInputNext = 1'b0;
                        dataInNext   = head.imm;
                        destNext     = head.dest;
                        writeEnNext  = 1'b1;
                    end
                    OP_ALU, OP_ALUC: begin
                        selInputNext = 1'b1;
                        funcNext     = head.func;
                        leftNext     = head.left;
                        rightNext    = head.right;
                        destNext     = head.dest;
                        crInNext     = (head.op == OP_ALUC) ? carryFlag : 1'b0;
                        writeEnNext  = 1'b1;
                        stateNext    = CARRY;
                    end
                    OP_READ: begin
                        leftNext  = head.left;
                        stateNext = READ;
                    end
                endcase
            end
            CARRY: begin
                carryNext = regCrOut;
                stateNext = ISSUE;
            end
            READ: begin
                respDataNext  = regDataOut;
                respValidNext = 1'b1;
                stateNext     = RESP;
            end
            RESP: if (respReady) begin
                respValidNext = 1'b0;
                stateNext     = ISSUE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ISSUE;
            wrPtr        <= '0;
            rdPtr        <= '0;
            regDataIn    <= '0;
            regFunc      <= '0;
            regCrIn      <= 1'b0;
            regLeftAddr  <= '0;
            regRightAddr <= '0;
            regDestAddr  <= '0;
            regWriteEn   <= 1'b0;
            regSelInput  <= 1'b0;
            respValid    <= 1'b0;
            respData     <= '0;
            carryFlag    <= 1'b0;
        end else begin
            state        <= stateNext;
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
            regDataIn    <= dataInNext;
            regFunc      <= funcNext;
            regCrIn      <= crInNext;
            regLeftAddr  <= leftNext;
            regRightAddr <= rightNext;
            regDestAddr  <= destNext;
            regWriteEn   <= writeEnNext;
            regSelInput  <= selInputNext;
            respValid    <= respValidNext;
            respData     <= respDataNext;
            carryFlag    <= carryNext;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic        retire;
    logic [15:0] retireCnt;

    // LOADI retires at issue, ALU/ALUC when leaving CARRY, READ at the response handshake.
    assign retire = (pop && head.op == OP_LOADI) || (state == CARRY) || (state == RESP && respReady);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       retireCnt <= '0;
        else if (retire) retireCnt <= retireCnt + 16'd1;
    end

    assign retireCount = retireCnt;
`else
    assign retireCount = '0;
`endif

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench for regfile_alu_sequencer with a behavioural register-file/ALU datapath attached.
// Expected retire count follows RETIRE_COUNT_EN.
module tb_regfile_alu_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmdValid, cmdReady;
    logic [1:0]        cmdOp;
    logic [2:0]        cmdFunc;
    logic [ADDR_W-1:0] cmdDest, cmdLeft, cmdRight;
    logic [DATA_W-1:0] cmdImm;
    logic              respValid, respReady;
    logic [DATA_W-1:0] respData;
    logic              carryFlag, busy;
    logic [DATA_W-1:0] regDataIn;
    logic [2:0]        regFunc;
    logic              regCrIn;
    logic [ADDR_W-1:0] regLeftAddr, regRightAddr, regDestAddr;
    logic              regWriteEn, regSelInput;
    logic [DATA_W-1:0] regDataOut;
    logic              regCrOut;
    logic [15:0]       retireCount;

    int checks = 0;
    int errors = 0;

    regfile_alu_sequencer #(.DEPTH(4), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdFunc(cmdFunc),
        .cmdDest(cmdDest), .cmdLeft(cmdLeft), .cmdRight(cmdRight), .cmdImm(cmdImm),
        .respValid(respValid), .respReady(respReady), .respData(respData),
        .carryFlag(carryFlag), .busy(busy),
        .regDataIn(regDataIn), .regFunc(regFunc), .regCrIn(regCrIn),
        .regLeftAddr(regLeftAddr), .regRightAddr(regRightAddr), .regDestAddr(regDestAddr),
        .regWriteEn(regWriteEn), .regSelInput(regSelInput),
        .regDataOut(regDataOut), .regCrOut(regCrOut), .retireCount(retireCount)
    );

    always #5 clock = ~clock;

    // Datapath: func 0 = add with carry-in, anything else = AND; forceCarry pins crOut high.
    logic [DATA_W-1:0] rf [16];
    logic [DATA_W:0]   aluSum;
    logic              forceCarry = 1'b0;

    always_comb begin
        if (regFunc == 3'd0)
            aluSum = {1'b0, rf[regLeftAddr]} + {1'b0, rf[regRightAddr]} + (DATA_W+1)'(regCrIn);
        else
            aluSum = {1'b0, rf[regLeftAddr] & rf[regRightAddr]};
    end
    assign regDataOut = rf[regLeftAddr];
    assign regCrOut   = aluSum[DATA_W] | forceCarry;

    always @(posedge clock) begin
        if (regWriteEn) rf[regDestAddr] <= regSelInput ? aluSum[DATA_W-1:0] : regDataIn;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [2:0] func, input logic [3:0] dest,
                        input logic [3:0] left, input logic [3:0] right, input logic [31:0] imm);
        int n = 0;
        while (!cmdReady && n < 50) begin
            tick();
            n++;
        end
        check("pushReadyTimeout", 32'(n < 50), 32'd1);
        cmdValid = 1'b1; cmdOp = op; cmdFunc = func;
        cmdDest = dest; cmdLeft = left; cmdRight = right; cmdImm = imm;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic waitResp(input string tag, input logic [31:0] exp);
        int n = 0;
        while (!respValid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "Timeout"}, 32'(n < 50), 32'd1);
        check(tag, respData, exp);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || respValid) && n < 100) begin
            tick();
            n++;
        end
        check("idleTimeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        reset = 1'b1; cmdValid = 1'b0; respReady = 1'b0;
        cmdOp = '0; cmdFunc = '0; cmdDest = '0; cmdLeft = '0; cmdRight = '0; cmdImm = '0;
        #12;
        check("rstRespValid", 32'(respValid), 32'd0);
        check("rstWriteEn", 32'(regWriteEn), 32'd0);
        check("rstBusy", 32'(busy), 32'd0);
        check("rstCmdReady", 32'(cmdReady), 32'd1);
        check("rstCarry", 32'(carryFlag), 32'd0);
        check("rstDataIn", regDataIn, 32'd0);
        check("rstRespData", respData, 32'd0);
        check("rstRetire", 32'(retireCount), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // LOADI r4=17 then READ r4.
        push(2'd0, 3'd0, 4'd4, 4'd0, 4'd0, 32'd17);
        push(2'd3, 3'd0, 4'd0, 4'd4, 4'd0, 32'd0);
        check("ldiWriteEn", 32'(regWriteEn), 32'd1);
        check("ldiSel", 32'(regSelInput), 32'd0);
        check("ldiData", regDataIn, 32'd17);
        check("ldiDest", 32'(regDestAddr), 32'd4);
        tick();
        check("readWriteEn", 32'(regWriteEn), 32'd0);
        check("readLeft", 32'(regLeftAddr), 32'd4);
        tick();
        check("respValid1", 32'(respValid), 32'd1);
        check("respData1", respData, 32'd17);
        respReady = 1'b1;
        tick();
        check("respCleared", 32'(respValid), 32'd0);
        respReady = 1'b0;

        // LOADI r6=2, ALU r1=r4+r6, READ r1.
        push(2'd0, 3'd0, 4'd6, 4'd0, 4'd0, 32'd2);
        push(2'd1, 3'd0, 4'd1, 4'd4, 4'd6, 32'd0);
        push(2'd3, 3'd0, 4'd0, 4'd1, 4'd0, 32'd0);
        check("aluWriteEn", 32'(regWriteEn), 32'd1);
        check("aluSel", 32'(regSelInput), 32'd1);
        check("aluFunc", 32'(regFunc), 32'd0);
        check("aluLeft", 32'(regLeftAddr), 32'd4);
        check("aluRight", 32'(regRightAddr), 32'd6);
        check("aluDest", 32'(regDestAddr), 32'd1);
        check("aluCrIn", 32'(regCrIn), 32'd0);
        tick();
        check("carryWriteEn", 32'(regWriteEn), 32'd0);
        waitResp("aluResp", 32'd19);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;

        // READ stalled in RESP while four LOADIs fill the FIFO.
        push(2'd3, 3'd0, 4'd0, 4'd1, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) push(2'd0, 3'd0, 4'(8 + i), 4'd0, 4'd0, 32'(100 + i));
        check("fullReady", 32'(cmdReady), 32'd0);
        check("stallRespValid", 32'(respValid), 32'd1);
        check("stallRespData", respData, 32'd19);
        tick();
        tick();
        check("heldRespValid", 32'(respValid), 32'd1);
        check("heldWriteEn", 32'(regWriteEn), 32'd0);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        check("ackRespValid", 32'(respValid), 32'd0);
        check("ackNoPop", 32'(regWriteEn), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drainWriteEn", 32'(regWriteEn), 32'd1);
            check("drainDest", 32'(regDestAddr), 32'(8 + i));
            check("drainData", regDataIn, 32'(100 + i));
        end
        check("drainReady", 32'(cmdReady), 32'd1);
        tick();
        check("drainDoneWe", 32'(regWriteEn), 32'd0);
        check("drainDoneBusy", 32'(busy), 32'd0);

        // Carry chaining: ALU with crOut forced high, then ALUC.
        forceCarry = 1'b1;
        push(2'd1, 3'd0, 4'd2, 4'd4, 4'd6, 32'd0);
        push(2'd2, 3'd0, 4'd3, 4'd4, 4'd6, 32'd0);
        check("chainAluCrIn", 32'(regCrIn), 32'd0);
        tick();
        check("carrySet", 32'(carryFlag), 32'd1);
        check("carryCycleWe", 32'(regWriteEn), 32'd0);
        tick();
        forceCarry = 1'b0;
        check("alucCrIn", 32'(regCrIn), 32'd1);
        check("alucWriteEn", 32'(regWriteEn), 32'd1);
        tick();
        check("carryCleared", 32'(carryFlag), 32'd0);
        tick();
        check("alucResult", rf[3], 32'd20);

        // Reset while in RESP with two commands queued.
        push(2'd3, 3'd0, 4'd0, 4'd2, 4'd0, 32'd0);
        push(2'd0, 3'd0, 4'd12, 4'd0, 4'd0, 32'd55);
        push(2'd0, 3'd0, 4'd13, 4'd0, 4'd0, 32'd66);
        check("preRstResp", 32'(respValid), 32'd1);
        check("preRstData", respData, 32'd19);
        check("preRstBusy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midRstRespValid", 32'(respValid), 32'd0);
        check("midRstWriteEn", 32'(regWriteEn), 32'd0);
        check("midRstBusy", 32'(busy), 32'd0);
        check("midRstReady", 32'(cmdReady), 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmdOp = 2'd0; cmdDest = 4'($urandom_range(0, 15)); cmdImm = $urandom;
            tick();
            check("postRstWe", 32'(regWriteEn), 32'd0);
            check("postRstBusy", 32'(busy), 32'd0);
        end
        check("queuedDropped", rf[12], 32'd0);

        // Retire counting: LOADI, ALU, ALUC, READ (acked), LOADI.
        respReady = 1'b1;
        push(2'd0, 3'd0, 4'd5, 4'd0, 4'd0, 32'd1);
        push(2'd1, 3'd0, 4'd7, 4'd5, 4'd6, 32'd0);
        push(2'd2, 3'd0, 4'd7, 4'd7, 4'd5, 32'd0);
        push(2'd3, 3'd0, 4'd0, 4'd7, 4'd0, 32'd0);
        push(2'd0, 3'd0, 4'd9, 4'd0, 4'd0, 32'd9);
        waitIdle();
        respReady = 1'b0;
        check("chainValue", rf[7], 32'd4);
`ifdef RETIRE_COUNT_EN
        check("retireCount", 32'(retireCount), 32'd5);
`else
        check("retireCount", 32'(retireCount), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
Command sequencer for the register-file-with-ALU datapath. It takes a stream of commands (load-immediate, ALU op, ALU op with carry chaining, register read) through a valid/ready port and buffers them in a small FIFO. It issues the commands in order by driving the datapath control pins (dataIn, func, crIn, left/right/dest addresses, writeEn, selInput), and returns read data through a valid/ready response port.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
DATA_W, 32, datapath word width
ADDR_W, 4, register address width (16 registers)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
cmdValid  in  1  command present
cmdReady  out  1  FIFO not full; command accepted on clock edge when cmdValid&&cmdReady
cmdOp  in  2  0=LOADI, 1=ALU, 2=ALUC, 3=READ
cmdFunc  in  3  ALU function code, passed through unchanged
cmdDest  in  ADDR_W  destination register
cmdLeft  in  ADDR_W  left operand register (READ: register to read)
cmdRight  in  ADDR_W  right operand register
cmdImm  in  DATA_W  immediate for LOADI
respValid  out  1  read data valid
respReady  in  1  consumer accepts read data
respData  out  DATA_W  read result
carryFlag  out  1  last captured ALU carry
busy  out  1  FIFO non-empty or FSM not in ISSUE
regDataIn  out  DATA_W  to datapath dataIn
regFunc  out  3  to datapath func
regCrIn  out  1  to datapath crIn
regLeftAddr, regRightAddr, regDestAddr  out  ADDR_W  to datapath address ports
regWriteEn  out  1  to datapath writeEn
regSelInput  out  1  to datapath selInput (0=dataIn, 1=ALU result)
regDataOut  in  DATA_W  from datapath dataOut (reads regfile[regLeftAddr])
regCrOut  in  1  from datapath crOut
retireCount  out  16  retired-command count (see Optional Feature)

Behaviour:
- Reset state (async): FIFO empty, FSM=ISSUE, all reg* outputs 0, respValid=0, respData=0, carryFlag=0, retireCount=0, busy=0. Reset mid-command aborts it. Pending responses and FIFO contents are discarded.
- All reg* outputs are registered. A command popped at edge N drives the datapath during cycle N..N+1. The datapath write commits at edge N+1.
- FIFO: cmdReady=!full. Push and pop in the same cycle are allowed when not full. A push while full cannot occur. Pointers wrap modulo DEPTH.
- FSM states: ISSUE, CARRY, READ, RESP.
- ISSUE, FIFO empty: regWriteEn=0, other reg* outputs hold.
- ISSUE, pop LOADI: regSelInput=0, regDataIn=cmdImm, regDestAddr=cmdDest, regWriteEn=1. Stay in ISSUE, so back-to-back LOADI runs at 1/cycle.
- ISSUE, pop ALU: regSelInput=1, regFunc/left/right/dest from command, regCrIn=0, regWriteEn=1. Go to CARRY.
- ISSUE, pop ALUC: same as ALU but regCrIn=carryFlag. Go to CARRY.
- ISSUE, pop READ: regLeftAddr=cmdLeft, regWriteEn=0. Go to READ.
- CARRY: regWriteEn=0, carryFlag<=regCrOut at end of cycle, no pop, then return to ISSUE. ALU/ALUC cost 2 cycles, so a following ALUC sees the updated carry.
- READ: respData<=regDataOut, respValid<=1. Go to RESP.
- RESP: hold respData/respValid. When respReady=1, clear respValid on that edge and return to ISSUE, with no pop in the same cycle.
- Write-then-read to the same register is safe: the write commits before the READ cycle.
- Command fields are captured at push. Changes to cmd* while cmdValid=0 have no effect.

Optional Feature:
RETIRE_COUNT_EN: when defined, retireCount increments by 1 (wrapping at 16 bits) for each LOADI issued, each ALU/ALUC on leaving CARRY, and each READ on response handshake. When undefined, retireCount is tied to 0 and the counter logic is not built.

Test Plan:
- Push LOADI dest4 imm17, then READ left4 -> regWriteEn=1 with regSelInput=0, regDataIn=17, regDestAddr=4 for one cycle; respValid=1, respData=17.
- LOADI r6=2, then ALU func0 dest1 left4 right6, then READ r1 -> ALU cycle shows regSelInput=1, regFunc=0, regLeftAddr=4, regRightAddr=6, regDestAddr=1, regWriteEn=1, followed by one writeEn=0 CARRY cycle; respData equals the datapath model result.
- READ with respReady=0, then push 4 LOADIs -> cmdReady=0 after the 4th push, respValid held. Raise respReady -> LOADIs issue in push order, one per cycle.
- ALU with regCrOut forced 1, then ALUC -> carryFlag=1 after CARRY; ALUC cycle drives regCrIn=1.
- Assert reset while in RESP with 2 commands queued -> immediately respValid=0, regWriteEn=0, busy=0, cmdReady=1; no queued command issues after release.
- With RETIRE_COUNT_EN, issue LOADI, ALU, ALUC, READ (acked), LOADI -> retireCount=5. Without the macro, retireCount stays 0.
